oled_spi_engine: RTL
====================

Name: oled_spi_engine

Overview:
- Parametrised successor to the fixed OLED serial driver.
- Runs the panel power-on reset sequence, then buffers command/data bytes in an internal FIFO. Bytes are serialised MSB-first on a 4-wire SPI link (SCLK, SDIN, CSb, DCb) at a programmable SCLK rate.
- Sits between the PLL-clocked system logic and the OLED pins. Upstream writers push bytes using a valid/ready handshake.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; must be >=1.
- RES_LOW_CYCLES, 1000: clk cycles OLED_RESb is held low during init.
- RES_WAIT_CYCLES, 10000: clk cycles after RESb rises before the first byte may be sent.
- FIFO_DEPTH, 16: byte FIFO depth; must be a power of 2 and >=2.

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  byte offered
- in_ready  out  1  FIFO can accept; high when FIFO not full
- in_data  in  8  byte to send
- in_dc  in  1  1 = data, 0 = command
- reinit  in  1  single-cycle pulse; re-runs the panel reset sequence
- init_done  out  1  panel reset sequence complete
- busy  out  1  state != IDLE or FIFO non-empty
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- OLED_RESb  out  1  panel reset, active low
- OLED_CSb  out  1  chip select, active low
- OLED_DCb  out  1  data/command select
- OLED_SDIN  out  1  serial data
- OLED_SCLK  out  1  serial clock; idles high (SPI mode 3)

Behaviour:
- Reset values (asynchronous, same instant rst rises):
  - OLED_RESb=0, OLED_CSb=1, OLED_SCLK=1, OLED_SDIN=0, OLED_DCb=0
  - init_done=0, level=0, FIFO emptied, state=RES_LOW
  - in_ready=1 after reset; pushes are accepted during init.
- Handshake:
  - A push occurs on any clk edge with in_valid && in_ready.
  - A push and a pop in the same cycle leave level unchanged.
  - A push while the FIFO is full is impossible, since in_ready=0.
- States and transitions:
  - RES_LOW: RESb=0 for RES_LOW_CYCLES cycles, then RES_WAIT.
  - RES_WAIT: RESb=1 for RES_WAIT_CYCLES cycles, then IDLE with init_done=1.
  - IDLE: CSb=1, SCLK=1. If FIFO non-empty, go to LOAD.
  - LOAD, 1 cycle: pop the FIFO; CSb=0; DCb=in_dc of the entry; SDIN=bit7; SCLK stays 1.
  - SHIFT: for each bit 7..0, SCLK=0 for CLK_DIV cycles (SDIN changes at the falling edge), then SCLK=1 for CLK_DIV cycles. The panel samples on the rising edge.
    - Byte time = 1 + 16*CLK_DIV cycles.
  - After the bit-0 high phase:
    - Pending reinit: go to HOLD.
    - Otherwise, FIFO non-empty: go to LOAD with CSb kept low, giving back-to-back bytes with one extra SCLK-high cycle between them.
    - Otherwise: go to HOLD.
  - HOLD: CSb stays 0 for CLK_DIV cycles, then CSb=1. Next state is RES_LOW if reinit is pending, else IDLE.
- reinit:
  - Latched as pending when pulsed.
  - Applied in IDLE immediately, clearing init_done.
  - Applied after the current byte's HOLD during transmission; the byte in flight is never truncated.
  - FIFO contents are retained and sent after the new init completes.
  - reinit during RES_LOW or RES_WAIT restarts RES_LOW.
- init_done is low in RES_LOW and RES_WAIT. No pop occurs while init_done=0.
- level wraps never; it saturates logically at FIFO_DEPTH because in_ready gates pushes.
- rst asserted mid-byte aborts immediately: the FIFO is lost, pins take reset values, and init restarts.

Optional Feature:
- Macro OLED_SPI_3WIRE_EN.
- Defined: 3-wire 9-bit frames. The DC bit is sent first, followed by data bits 7..0. OLED_DCb is held 0. Byte time = 1 + 18*CLK_DIV cycles.
- Undefined: 4-wire mode as described above.

Decomposition:
- Package oled_pkg holds:
  - the state enum (RES_LOW, RES_WAIT, IDLE, LOAD, SHIFT, HOLD)
  - the FIFO entry width constant (9: {dc, data})
  - the SCLK idle level constant
- One sub-module, oled_byte_fifo: a synchronous FIFO with async-reset pointers, width 9, depth FIFO_DEPTH, providing full, empty and level.

Test Plan:
Bench parameters: CLK_DIV=2, RES_LOW_CYCLES=4, RES_WAIT_CYCLES=8, FIFO_DEPTH=4.
1. Release rst -> RESb=0 for 4 cycles, then 1; init_done=1 8 cycles later; CSb=1 and SCLK=1 throughout.
2. After init, push 0xA5 with dc=0 -> CSb=0 for 33 cycles plus 2 HOLD cycles; 8 rising SCLK edges sample 1,0,1,0,0,1,0,1; DCb=0.
3. Push 4 bytes (0x01 dc=0, 0x02 dc=1, 0x03 dc=1, 0x04 dc=0) -> in_ready=0 at level 4; CSb stays low across all 4 bytes; DCb matches each byte at its rising edges; busy falls after the final HOLD.
4. Assert rst at the 3rd rising edge of a byte -> CSb=1, RESb=0, SCLK=1 immediately; level=0.
5. Pulse reinit during a byte with 2 bytes queued -> current byte completes; RESb low 4 cycles, init_done drops; the 2 queued bytes are sent after init_done reasserts.
6. With OLED_SPI_3WIRE_EN defined, push 0x3C with dc=1 -> 9 rising edges sample 1,0,0,1,1,1,1,0,0; DCb stays 0; CSb low for 37 cycles plus HOLD.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI engine and its byte FIFO.
package oled_pkg;

  typedef enum logic [2:0] {
    StResLow,
    StResWait,
    StIdle,
    StLoad,
    StShift,
    StHold
  } oled_state_e;

  // FIFO entry layout is {dc, data[7:0]}.
  localparam int unsigned EntryW = 9;

  // SPI mode 3: SCLK rests high between frames.
  localparam logic SclkIdle = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oled_byte_fifo.sv
// Synchronous FIFO holding {dc, data} entries; pointers reset asynchronously, storage does not.
module oled_byte_fifo
  import oled_pkg::*;
#(
  parameter int unsigned Width = EntryW,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [LevelW-1:0] wptr_q, rptr_q;
  logic              do_push, do_pop;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == LevelW'(Depth));
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + LevelW'(1);
      if (do_pop)  rptr_q <= rptr_q + LevelW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/oled_spi_engine.sv
// OLED panel driver: reset sequencing, byte FIFO and MSB-first SPI mode-3 serialiser.
// Define OLED_SPI_3WIRE_EN for 9-bit 3-wire frames (DC bit first, OLED_DCb held low).
module oled_spi_engine
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned RES_LOW_CYCLES  = 1000,
  parameter int unsigned RES_WAIT_CYCLES = 10000,
  parameter int unsigned FIFO_DEPTH      = 16,
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_dc,
  input  logic              reinit,
  output logic              init_done,
  output logic              busy,
  output logic [LevelW-1:0] level,
  output logic              OLED_RESb,
  output logic              OLED_CSb,
  output logic              OLED_DCb,
  output logic              OLED_SDIN,
  output logic              OLED_SCLK
);

`ifdef OLED_SPI_3WIRE_EN
  localparam int unsigned NumBits = 9;
`else
  localparam int unsigned NumBits = 8;
`endif

  localparam int unsigned CntW = $clog2(max3(CLK_DIV, RES_LOW_CYCLES, RES_WAIT_CYCLES) + 1);
  localparam logic [CntW-1:0] LowLast  = CntW'(RES_LOW_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(RES_WAIT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [3:0]      BitLast  = 4'(NumBits - 1);

  oled_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [EntryW-1:0] sh_q, sh_d;
  logic              sclk_q, sclk_d;
  logic              csb_q, csb_d;
  logic              dcb_q, dcb_d;
  logic              resb_q, resb_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;

  logic              load, reinit_any;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_rdata;
  logic [EntryW-1:0] frame;
  logic              frame_dc;

  oled_byte_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (in_valid && in_ready),
    .wdata_i({in_dc, in_data}),
    .pop_i  (load),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(level)
  );

  // The shift register is always MSB-aligned so OLED_SDIN is simply its top bit.
`ifdef OLED_SPI_3WIRE_EN
  assign frame    = fifo_rdata;
  assign frame_dc = 1'b0;
`else
  assign frame    = {fifo_rdata[7:0], 1'b0};
  assign frame_dc = fifo_rdata[8];
`endif

  assign reinit_any = reinit || pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    csb_d   = csb_q;
    dcb_d   = dcb_q;
    pend_d  = pend_q | reinit;
    load    = 1'b0;

    unique case (state_q)
      StResLow: begin
        if (reinit) begin
          cnt_d = '0;
        end else if (cnt_q == LowLast) begin
          state_d = StResWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResWait: begin
        if (reinit) begin
          state_d = StResLow;
          cnt_d   = '0;
        end else if (cnt_q == WaitLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdle: begin
        if (reinit_any) begin
          state_d = StResLow;
          cnt_d   = '0;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      StLoad: begin
        state_d = StShift;
        cnt_d   = '0;
        bit_d   = BitLast;
        sclk_d  = 1'b0;
      end
      StShift: begin
        if (cnt_q != DivLast) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q != 4'd0) begin
            bit_d  = bit_q - 4'd1;
            sclk_d = 1'b0;
            sh_d   = {sh_q[EntryW-2:0], 1'b0};
          end else if (!reinit_any && !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (cnt_q != DivLast) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d   = '0;
          csb_d   = 1'b1;
          state_d = reinit_any ? StResLow : StIdle;
        end
      end
      default: begin
        state_d = StResLow;
        cnt_d   = '0;
        csb_d   = 1'b1;
        sclk_d  = SclkIdle;
      end
    endcase

    // Pop and present the head entry on the edge that enters LOAD.
    if (load) begin
      state_d = StLoad;
      csb_d   = 1'b0;
      sh_d    = frame;
      dcb_d   = frame_dc;
    end

    if (state_d == StResLow) pend_d = 1'b0;
  end

  assign resb_d = (state_d != StResLow);
  assign done_d = !(state_d inside {StResLow, StResWait});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StResLow;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= SclkIdle;
      csb_q   <= 1'b1;
      dcb_q   <= 1'b0;
      resb_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      csb_q   <= csb_d;
      dcb_q   <= dcb_d;
      resb_q  <= resb_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign init_done = done_q;
  assign OLED_RESb = resb_q;
  assign OLED_CSb  = csb_q;
  assign OLED_DCb  = dcb_q;
  assign OLED_SDIN = sh_q[EntryW-1];
  assign OLED_SCLK = sclk_q;

endmodule
